// File: rtl/cumulative_histogram_dual.sv
// ============================================================================
// cumulative_histogram_dual: single-pass cumulative histogram with low/high
// percentile threshold search. Optional macro CUMHIST_CLEAR_EN enables
// clear-on-read of the source histogram RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cumulative_histogram_dual #(
    parameter int WORD_SIZE = 20,
    parameter int BIN_BITS  = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic                 iAck,
    input  logic [WORD_SIZE-1:0] iPctLo,
    input  logic [WORD_SIZE-1:0] iPctHi,
    input  logic [WORD_SIZE-1:0] iQInHist,
    output logic [BIN_BITS-1:0]  oAddrInHist,
    output logic                 oWE,
    output logic [BIN_BITS-1:0]  oAddrOutCumH,
    output logic [WORD_SIZE-1:0] oDataOutCumH,
    output logic                 oClrWE,
    output logic [BIN_BITS-1:0]  oClrAddr,
    output logic [BIN_BITS-1:0]  oThreshLo,
    output logic [BIN_BITS-1:0]  oThreshHi,
    output logic                 oLoFound,
    output logic                 oHiFound,
    output logic                 oOverflow,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam logic [BIN_BITS-1:0] LAST_BIN = {BIN_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WORD_SIZE-1:0] pct_lo, pct_hi, acc;
    logic                 lo_hit, hi_hit;
    logic [BIN_BITS-1:0]  lo_bin, hi_bin;
    logic                 pipe_vld [RD_LAT];
    logic [BIN_BITS-1:0]  pipe_bin [RD_LAT];

    logic                 sample;
    logic [BIN_BITS-1:0]  sample_bin;
    logic [WORD_SIZE:0]   sum;
    logic [WORD_SIZE-1:0] cum;
    logic                 last_write;

    assign sample     = pipe_vld[RD_LAT-1];
    assign sample_bin = pipe_bin[RD_LAT-1];
    assign sum        = {1'b0, acc} + {1'b0, iQInHist};
    // A carry out pins the running sum at full scale.
    assign cum        = sum[WORD_SIZE] ? {WORD_SIZE{1'b1}} : sum[WORD_SIZE-1:0];
    assign last_write = oWE && (oAddrOutCumH == LAST_BIN);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            SCAN:    if (oAddrInHist == LAST_BIN) state_nx = DRAIN;
            DRAIN:   if (last_write) state_nx = DONE;
            DONE:    if (iAck) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A new start aborts whatever is in progress.
        if (iStart) state_nx = SCAN;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pct_lo       <= '0;
            pct_hi       <= '0;
            acc          <= '0;
            lo_hit       <= 1'b0;
            hi_hit       <= 1'b0;
            lo_bin       <= '0;
            hi_bin       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_bin[i] <= '0;
            end
            oAddrInHist  <= '0;
            oWE          <= 1'b0;
            oAddrOutCumH <= '0;
            oDataOutCumH <= '0;
            oThreshLo    <= '0;
            oThreshHi    <= '0;
            oLoFound     <= 1'b0;
            oHiFound     <= 1'b0;
            oOverflow    <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
        end else if (iStart) begin
            pct_lo       <= iPctLo;
            pct_hi       <= iPctHi;
            acc          <= '0;
            lo_hit       <= 1'b0;
            hi_hit       <= 1'b0;
            lo_bin       <= '0;
            hi_bin       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_bin[i] <= '0;
            end
            oAddrInHist  <= '0;
            oWE          <= 1'b0;
            oAddrOutCumH <= '0;
            oDataOutCumH <= '0;
            oThreshLo    <= '0;
            oThreshHi    <= '0;
            oLoFound     <= 1'b0;
            oHiFound     <= 1'b0;
            oOverflow    <= 1'b0;
            oBusy        <= 1'b1;
            oDone        <= 1'b0;
        end else begin
            // Address wraps to zero after the last bin, leaving it parked at 0.
            if (state == SCAN) oAddrInHist <= oAddrInHist + BIN_BITS'(1);

            pipe_vld[0] <= (state == SCAN);
            pipe_bin[0] <= oAddrInHist;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_bin[i] <= pipe_bin[i-1];
            end

            if (sample) begin
                acc          <= cum;
                oWE          <= 1'b1;
                oAddrOutCumH <= sample_bin;
                oDataOutCumH <= cum;
                if (sum[WORD_SIZE]) oOverflow <= 1'b1;
                if (!lo_hit && (cum > pct_lo)) begin
                    lo_hit <= 1'b1;
                    lo_bin <= sample_bin;
                end
                if (!hi_hit && (cum > pct_hi)) begin
                    hi_hit <= 1'b1;
                    hi_bin <= sample_bin;
                end
            end else begin
                oWE          <= 1'b0;
                oAddrOutCumH <= '0;
                oDataOutCumH <= '0;
            end

            // Results become visible only once the whole pass is written.
            if ((state == DRAIN) && last_write) begin
                oDone     <= 1'b1;
                oBusy     <= 1'b0;
                oThreshLo <= lo_hit ? lo_bin : LAST_BIN;
                oThreshHi <= hi_hit ? hi_bin : LAST_BIN;
                oLoFound  <= lo_hit;
                oHiFound  <= hi_hit;
            end

            if ((state == DONE) && iAck) oDone <= 1'b0;
        end
    end

`ifdef CUMHIST_CLEAR_EN
    // Zero each source bin alongside its cumulative write.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oClrWE   <= 1'b0;
            oClrAddr <= '0;
        end else if (iStart) begin
            oClrWE   <= 1'b0;
            oClrAddr <= '0;
        end else begin
            oClrWE   <= sample;
            oClrAddr <= sample ? sample_bin : '0;
        end
    end
`else
    assign oClrWE   = 1'b0;
    assign oClrAddr = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cumulative_histogram_dual.md
Name: cumulative_histogram_dual

Overview:
Parametrised successor to the frame cumulative-histogram block. Reads a NUM_BINS-entry histogram RAM with a configurable read latency, writes the running cumulative sum to a second RAM, and finds two runtime-programmable percentile thresholds (low and high) in one pass. Sits between the per-frame histogram accumulator and the thresholding/contrast-stretch stage. Completion is held until acknowledged.

Parameters:
WORD_SIZE, 20, width of histogram counts and cumulative sums.
BIN_BITS, 8, bin index width; NUM_BINS = 2**BIN_BITS.
RD_LAT, 1, histogram RAM read latency in cycles (legal values 1..3).

Ports:
iClk  in  1  clock.
iRst  in  1  asynchronous active-high reset.
iStart  in  1  one-cycle start pulse; samples iPctLo/iPctHi.
iAck  in  1  acknowledges oDone; returns block to IDLE.
iPctLo  in  WORD_SIZE  low percentile count target.
iPctHi  in  WORD_SIZE  high percentile count target.
iQInHist  in  WORD_SIZE  histogram RAM read data.
oAddrInHist  out  BIN_BITS  histogram RAM read address.
oWE  out  1  cumulative RAM write enable.
oAddrOutCumH  out  BIN_BITS  cumulative RAM write address.
oDataOutCumH  out  WORD_SIZE  cumulative RAM write data.
oClrWE  out  1  histogram RAM clear write enable (see Optional Feature).
oClrAddr  out  BIN_BITS  histogram RAM clear address.
oThreshLo  out  BIN_BITS  low threshold bin.
oThreshHi  out  BIN_BITS  high threshold bin.
oLoFound, oHiFound  out  1 each  target exceeded within the histogram.
oOverflow  out  1  cumulative sum saturated.
oBusy  out  1  scan in progress.
oDone  out  1  result valid; held until iAck.

Behaviour:
- Reset (async): all outputs 0; state IDLE; accumulator 0; latched targets 0.
- States: IDLE -> SCAN (iStart) -> DRAIN -> DONE -> IDLE (iAck).
- iStart in any state (incl. SCAN/DRAIN/DONE) aborts and restarts: accumulator, found flags, thresholds and oOverflow cleared; targets relatched. iStart beats iAck on the same cycle.
- Let S be the cycle iStart is sampled. oAddrInHist = b on cycle S+1+b, b = 0..NUM_BINS-1; oBusy high from S+1 until oDone rises.
- hist[b] is sampled from iQInHist at the end of cycle S+1+b+RD_LAT. A shift-register valid/address pipeline of depth RD_LAT tracks it.
- cum[b] = sum of hist[0..b], width WORD_SIZE. If the add carries out, the sum saturates to all-ones and oOverflow sets (sticky until next iStart).
- Write: on cycle S+2+b+RD_LAT, oWE=1, oAddrOutCumH=b, oDataOutCumH=cum[b]. oWE is 0 otherwise.
- Threshold rule: oThreshLo is the smallest b with cum[b] > PctLo (strict). It is captured on the first hit and oLoFound is set. Same rule for Hi, evaluated independently; no ordering between Lo and Hi is required.
- No hit: threshold = NUM_BINS-1, found flag = 0. Thresholds update only at DRAIN->DONE.
- Target 0 with hist[0]=0 does not hit at bin 0 (strict compare).
- oDone rises on cycle S+NUM_BINS+RD_LAT+2 (one after the last write) and stays high until iAck; it is then low the next cycle.
- Results (oThresh*, flags, oOverflow) hold their values in DONE and IDLE until the next iStart.
- iAck outside DONE is ignored.
- After oDone falls, oAddrInHist, oAddrOutCumH and oDataOutCumH are 0.

Optional Feature:
- Macro: CUMHIST_CLEAR_EN.
- Defined: the block writes zero back to the histogram RAM for each bin in the cycle after that bin is sampled. oClrWE=1 and oClrAddr=b on cycle S+2+b+RD_LAT, so the next frame accumulates from zero with no separate clear pass.
- Not defined: oClrWE and oClrAddr are tied 0; histogram RAM contents are untouched.

Test Plan:
- Flat histogram, NUM_BINS=256, all bins=1500, PctLo=192000, PctHi=345600, RD_LAT=1 -> cum[b]=1500*(b+1); oThreshLo=128, oThreshHi=230, both found; oDone at S+259.
- All counts in bin 77 (384000), PctLo=0, PctHi=383999 -> both thresholds 77, cum[76]=0, cum[255]=384000.
- Empty histogram, PctLo=5 -> oLoFound=0, oThreshLo=255, all 256 writes are 0, oDone still asserted.
- WORD_SIZE=20, every bin=8192 -> oOverflow=1 from bin 127 onward, cum saturates at 1048575.
- RD_LAT=3, iStart reasserted mid-scan at bin 100 with new targets -> clean restart; only new-pass results; oDone at S'+261.
- CUMHIST_CLEAR_EN defined -> every histogram bin reads 0 after oDone; oDone held 10 cycles until iAck, then low.
